// File: rtl/fetch_sequencer.sv
// Fetch-stage control: merges branch redirects, hazard stalls and a single-level
// interrupt (drain -> redirect -> ISR) into fetch's flush/flush_pc/stall inputs.
module fetch_sequencer #(
  parameter int unsigned            ADDR_WIDTH = 10,
  parameter logic [ADDR_WIDTH-1:0]  ISR_VECTOR = ADDR_WIDTH'(1000)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] pc_in,
  input  logic                  branch_taken,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  input  logic                  hazard_stall,
  input  logic                  pipe_busy,
  input  logic                  irq,
  input  logic                  irq_enable,
  input  logic                  reti,
  output logic                  flush,
  output logic [ADDR_WIDTH-1:0] flush_pc,
  output logic                  stall,
  output logic                  irq_ack,
  output logic                  in_isr,
  output logic [ADDR_WIDTH-1:0] saved_pc,
  output logic [7:0]            drain_cycles
);

  typedef enum logic [1:0] {
    NORMAL = 2'd0,
    IRQ_S1 = 2'd1,
    IRQ_S2 = 2'd2,
    ISR    = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] saved_pc_q, saved_pc_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [7:0]            drain_q, drain_d;
  logic                  ack_q, ack_d;
  logic [7:0]            cnt_inc;

  assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

  always_comb begin
    state_d    = state_q;
    saved_pc_d = saved_pc_q;
    cnt_d      = cnt_q;
    drain_d    = drain_q;
    ack_d      = 1'b0;
    flush      = 1'b0;
    flush_pc   = '0;
    stall      = 1'b0;

    case (state_q)
      NORMAL: begin
        if (branch_taken) begin
          flush    = 1'b1;
          flush_pc = branch_target;
        end else if (irq && irq_enable) begin
          stall      = 1'b1;
          saved_pc_d = pc_in;
          cnt_d      = '0;
          state_d    = IRQ_S1;
        end else begin
          stall = hazard_stall;
        end
      end
      IRQ_S1: begin
        // A branch resolving while draining becomes the new return address.
        stall = 1'b1;
        cnt_d = cnt_inc;
        if (branch_taken) begin
          flush      = 1'b1;
          flush_pc   = branch_target;
          saved_pc_d = branch_target;
        end else if (!pipe_busy) begin
          drain_d = cnt_inc;
          state_d = IRQ_S2;
        end
      end
      IRQ_S2: begin
        flush    = 1'b1;
        flush_pc = ISR_VECTOR;
        ack_d    = 1'b1;
        state_d  = ISR;
      end
      ISR: begin
        if (reti) begin
          flush    = 1'b1;
          flush_pc = saved_pc_q;
          state_d  = NORMAL;
        end else if (branch_taken) begin
          flush    = 1'b1;
          flush_pc = branch_target;
        end else begin
          stall = hazard_stall;
        end
      end
      default: state_d = NORMAL;
    endcase

    if (rst) begin
      flush    = 1'b0;
      flush_pc = '0;
      stall    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= NORMAL;
      saved_pc_q <= '0;
      cnt_q      <= '0;
      drain_q    <= '0;
      ack_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      saved_pc_q <= saved_pc_d;
      cnt_q      <= cnt_d;
      drain_q    <= drain_d;
      ack_q      <= ack_d;
    end
  end

  assign in_isr       = !rst && (state_q == ISR);
  assign irq_ack      = ack_q;
  assign saved_pc     = saved_pc_q;
  assign drain_cycles = drain_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: reset, branch/hazard, interrupt entry/exit,
// branch during drain, reti priority, reset mid-entry.
module tb_fetch_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] pc_in;
  logic       branch_taken;
  logic [9:0] branch_target;
  logic       hazard_stall;
  logic       pipe_busy;
  logic       irq;
  logic       irq_enable;
  logic       reti;
  logic       flush;
  logic [9:0] flush_pc;
  logic       stall;
  logic       irq_ack;
  logic       in_isr;
  logic [9:0] saved_pc;
  logic [7:0] drain_cycles;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_sequencer #(.ADDR_WIDTH(10), .ISR_VECTOR(10'd1000)) dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .branch_taken(branch_taken),
    .branch_target(branch_target), .hazard_stall(hazard_stall),
    .pipe_busy(pipe_busy), .irq(irq), .irq_enable(irq_enable), .reti(reti),
    .flush(flush), .flush_pc(flush_pc), .stall(stall), .irq_ack(irq_ack),
    .in_isr(in_isr), .saved_pc(saved_pc), .drain_cycles(drain_cycles)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Inputs settle, then the combinational outputs are compared well before the next edge.
  task automatic chk_out(input string tag, input logic f, input logic [9:0] fpc, input logic s);
    #1;
    check_eq({tag, ".flush"}, 32'(flush), 32'(f));
    if (f) check_eq({tag, ".flush_pc"}, 32'(flush_pc), 32'(fpc));
    check_eq({tag, ".stall"}, 32'(stall), 32'(s));
  endtask

  initial begin
    rst = 1'b1; pc_in = '0; branch_taken = 1'b0; branch_target = '0;
    hazard_stall = 1'b0; pipe_busy = 1'b0; irq = 1'b0; irq_enable = 1'b0; reti = 1'b0;
    cyc(); cyc();

    // Outputs forced low while in reset, even with requests present
    branch_taken = 1'b1; branch_target = 10'd200; hazard_stall = 1'b1;
    #1;
    check_eq("rst.flush", 32'(flush), 0);
    check_eq("rst.flush_pc", 32'(flush_pc), 0);
    check_eq("rst.stall", 32'(stall), 0);
    check_eq("rst.in_isr", 32'(in_isr), 0);
    check_eq("rst.saved_pc", 32'(saved_pc), 0);
    check_eq("rst.irq_ack", 32'(irq_ack), 0);
    check_eq("rst.drain", 32'(drain_cycles), 0);
    cyc();
    rst = 1'b0; branch_taken = 1'b0; hazard_stall = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk_out("idle", 1'b0, '0, 1'b0);
      check_eq("idle.in_isr", 32'(in_isr), 0);
      check_eq("idle.saved_pc", 32'(saved_pc), 0);
      cyc();
    end

    // Branch and hazard in NORMAL
    branch_taken = 1'b1; branch_target = 10'd200;
    chk_out("br", 1'b1, 10'd200, 1'b0);
    cyc();
    branch_taken = 1'b0; hazard_stall = 1'b1;
    chk_out("haz", 1'b0, '0, 1'b1);
    cyc();
    hazard_stall = 1'b0; irq = 1'b1; irq_enable = 1'b0;
    chk_out("irq_dis", 1'b0, '0, 1'b0);
    cyc();
    chk_out("irq_dis2", 1'b0, '0, 1'b0);
    irq = 1'b0; reti = 1'b1;
    chk_out("reti_norm", 1'b0, '0, 1'b0);
    cyc();
    reti = 1'b0;
    #1 check_eq("reti_norm.in_isr", 32'(in_isr), 0);

    // Entry with three busy cycles: pc 50, drain 3
    pc_in = 10'd50; irq = 1'b1; irq_enable = 1'b1; pipe_busy = 1'b1;
    chk_out("e1.c0", 1'b0, '0, 1'b1);
    cyc();
    irq = 1'b0;
    chk_out("e1.c1", 1'b0, '0, 1'b1);
    check_eq("e1.c1.in_isr", 32'(in_isr), 0);
    cyc();
    chk_out("e1.c2", 1'b0, '0, 1'b1);
    cyc();
    pipe_busy = 1'b0;
    chk_out("e1.c3", 1'b0, '0, 1'b1);
    cyc();
    irq = 1'b1;
    chk_out("e1.s2", 1'b1, 10'd1000, 1'b0);
    check_eq("e1.s2.ack", 32'(irq_ack), 0);
    cyc();
    check_eq("e1.ack", 32'(irq_ack), 1);
    check_eq("e1.in_isr", 32'(in_isr), 1);
    check_eq("e1.saved_pc", 32'(saved_pc), 50);
    check_eq("e1.drain", 32'(drain_cycles), 3);
    chk_out("e1.isr", 1'b0, '0, 1'b0);
    cyc();
    hazard_stall = 1'b1;
    check_eq("e1.ack_drop", 32'(irq_ack), 0);
    chk_out("e1.isr_haz", 1'b0, '0, 1'b1);
    cyc();
    check_eq("e1.no_nest", 32'(irq_ack), 0);
    hazard_stall = 1'b0; branch_taken = 1'b1; branch_target = 10'd120;
    chk_out("e1.isr_br", 1'b1, 10'd120, 1'b0);
    cyc();
    branch_target = 10'd77; reti = 1'b1; irq = 1'b0;
    chk_out("e1.reti_br", 1'b1, 10'd50, 1'b0);
    cyc();
    branch_taken = 1'b0; reti = 1'b0;
    chk_out("e1.back", 1'b0, '0, 1'b0);
    check_eq("e1.back.in_isr", 32'(in_isr), 0);

    // Branch during drain replaces the return address
    pc_in = 10'd60; irq = 1'b1;
    chk_out("e2.c0", 1'b0, '0, 1'b1);
    cyc();
    irq = 1'b0; branch_taken = 1'b1; branch_target = 10'd300;
    chk_out("e2.s1br", 1'b1, 10'd300, 1'b1);
    cyc();
    branch_taken = 1'b0;
    chk_out("e2.s1", 1'b0, '0, 1'b1);
    check_eq("e2.saved", 32'(saved_pc), 300);
    cyc();
    chk_out("e2.s2", 1'b1, 10'd1000, 1'b0);
    cyc();
    check_eq("e2.ack", 32'(irq_ack), 1);
    check_eq("e2.drain", 32'(drain_cycles), 2);
    reti = 1'b1;
    chk_out("e2.reti", 1'b1, 10'd300, 1'b0);
    cyc();
    reti = 1'b0;
    #1 check_eq("e2.back.in_isr", 32'(in_isr), 0);

    // Minimum latency: ack three cycles after irq sampled
    pc_in = 10'd70; irq = 1'b1;
    chk_out("e3.c0", 1'b0, '0, 1'b1);
    cyc();
    irq = 1'b0;
    chk_out("e3.s1", 1'b0, '0, 1'b1);
    cyc();
    chk_out("e3.s2", 1'b1, 10'd1000, 1'b0);
    cyc();
    check_eq("e3.ack", 32'(irq_ack), 1);
    check_eq("e3.drain", 32'(drain_cycles), 1);
    check_eq("e3.saved", 32'(saved_pc), 70);
    cyc();
    check_eq("e3.ack_drop", 32'(irq_ack), 0);
    check_eq("e3.in_isr", 32'(in_isr), 1);
    reti = 1'b1;
    chk_out("e3.reti", 1'b1, 10'd70, 1'b0);
    cyc();
    reti = 1'b0;

    // Reset while draining aborts entry
    pc_in = 10'd80; irq = 1'b1; pipe_busy = 1'b1;
    chk_out("e4.c0", 1'b0, '0, 1'b1);
    cyc();
    rst = 1'b1;
    chk_out("e4.rst", 1'b0, '0, 1'b0);
    cyc();
    rst = 1'b0; irq = 1'b0; pipe_busy = 1'b0;
    chk_out("e4.after", 1'b0, '0, 1'b0);
    check_eq("e4.saved", 32'(saved_pc), 0);
    for (int i = 0; i < 3; i++) begin
      check_eq("e4.no_ack", 32'(irq_ack), 0);
      check_eq("e4.in_isr", 32'(in_isr), 0);
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Control block that drives the fetch stage's `flush`, `flush_pc` and `stall` inputs. It merges three sources: branch redirects (BZ/JMP resolved downstream), downstream hazard stalls, and a single-level interrupt. Interrupt entry runs as a two-stage sequence (drain, then redirect), followed by an in-ISR state that ends on return-from-interrupt. The block sits beside the fetch stage. Its flush output also invalidates the downstream pipeline registers.

## Interface
- `ADDR_WIDTH`, default 10: width of all PC values.
- `ISR_VECTOR`, default 10'd1000: PC loaded on interrupt entry.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `pc_in` in ADDR_WIDTH: current fetch PC (fetch's program_counter_for_stages).
- `branch_taken` in 1: resolved taken BZ/JMP this cycle.
- `branch_target` in ADDR_WIDTH: redirect target, valid with `branch_taken`.
- `hazard_stall` in 1: downstream requests fetch hold.
- `pipe_busy` in 1: at least one valid instruction is in flight past fetch.
- `irq` in 1: level interrupt request.
- `irq_enable` in 1: global interrupt enable.
- `reti` in 1: return-from-interrupt resolved this cycle.
- `flush` out 1: redirect fetch and kill younger instructions.
- `flush_pc` out ADDR_WIDTH: redirect target, meaningful only when `flush`=1.
- `stall` out 1: hold fetch PC.
- `irq_ack` out 1: one-cycle pulse when the ISR redirect is issued.
- `in_isr` out 1: state is ISR.
- `saved_pc` out ADDR_WIDTH: captured return address.
- `drain_cycles` out 8: cycles spent in the last IRQ_S1 visit, saturating at 255.

## Operation
- States: NORMAL=0, IRQ_S1=1, IRQ_S2=2, ISR=3. `state`, `saved_pc`, `irq_ack`, `drain_cycles` and an internal drain counter are registered. `flush`, `flush_pc` and `stall` are combinational from state and inputs.
- Reset (while `rst`=1): state→NORMAL, `saved_pc`→0, `drain_cycles`→0, `irq_ack`→0. `flush`, `stall` and `in_isr` are forced to 0, and `flush_pc` reads 0.
- NORMAL, priority order:
  - `branch_taken` → `flush`=1, `flush_pc`=`branch_target`. State is unchanged, and any irq is deferred one cycle.
  - Else `irq & irq_enable` → `stall`=1, `saved_pc`←`pc_in`, drain counter←0, next state IRQ_S1.
  - Else `stall`=`hazard_stall`.
- IRQ_S1 (drain):
  - `stall`=1 every cycle.
  - If `branch_taken`: `flush`=1, `flush_pc`=`branch_target`, `saved_pc`←`branch_target`. Fetch is still redirected to the target.
  - The drain counter increments (saturating) each cycle.
  - When `pipe_busy`=0 and `branch_taken`=0: `drain_cycles`←counter, next state IRQ_S2.
  - `irq` deasserting in IRQ_S1 does not abort entry.
- IRQ_S2: `flush`=1, `flush_pc`=`ISR_VECTOR`, `stall`=0, `irq_ack`←1 (visible the following cycle for exactly one cycle), next state ISR.
- ISR:
  - `in_isr`=1. `irq` is ignored (no nesting).
  - `reti` → `flush`=1, `flush_pc`=`saved_pc`, next state NORMAL. `reti` has priority over a simultaneous `branch_taken`.
  - Else `branch_taken` → flush to `branch_target`.
  - Else `stall`=`hazard_stall`.
- `flush`=1 always implies `stall`=0 at the output, except in IRQ_S1 with a branch, where both are 1; fetch gives flush priority.
- `reti` in any state other than ISR is ignored.

## Timing
- Branch redirect: zero-cycle combinational `flush`. Fetch loads `branch_target` at the next edge.
- Interrupt entry latency:
  - Cycle 0 (NORMAL, irq seen): `stall`=1.
  - Cycles 1..N (IRQ_S1): `stall`=1, N ≥ 1, ending in the first cycle with `pipe_busy`=0.
  - Cycle N+1 (IRQ_S2): `flush` to `ISR_VECTOR`.
  - Cycle N+2: `irq_ack`=1 and `in_isr`=1; fetch PC = `ISR_VECTOR`.
- With `pipe_busy`=0 throughout, the minimum is `irq_ack` 3 cycles after irq is sampled; `drain_cycles`=1.
- `irq_ack` is registered and high for one cycle only.
- `rst` mid-sequence, from any state, returns to NORMAL at the next edge with no ack.

## Test plan
- Reset, then idle inputs → `flush`=0, `stall`=0, `in_isr`=0, `saved_pc`=0 each cycle.
- NORMAL, `branch_taken`=1, `branch_target`=10'd200 → `flush`=1, `flush_pc`=200 in the same cycle; `hazard_stall`=1 alone → `stall`=1 with `flush`=0.
- `pc_in`=10'd50, `irq`=1, `irq_enable`=1, `pipe_busy`=1 for 3 cycles then 0 → `stall` high for 4 cycles, then `flush_pc`=1000, then `irq_ack` pulse and `in_isr`=1; `saved_pc`=50, `drain_cycles`=3.
- During IRQ_S1, `branch_taken`, `branch_target`=10'd300 → `flush_pc`=300, `saved_pc`=300; after `reti` in ISR, `flush_pc`=300.
- ISR with `reti` and `branch_taken` (target 10'd77) in the same cycle → `flush_pc`=`saved_pc`, state NORMAL; `irq` held high in ISR → no second ack.
- `rst` asserted in IRQ_S1 → next cycle NORMAL, `stall`=0, `irq_ack` never pulses; `irq` with `irq_enable`=0 → no entry.
